// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: register names, ALU ops and control bundle shared by the ID/EX register
package id_ex_pipe_reg_pkg;
   typedef enum logic [4:0] {
      zero, x1, x2, x3, x4, x5, x6, x7, x8, x9, x10, x11, x12, x13, x14, x15,
      x16, x17, x18, x19, x20, x21, x22, x23, x24, x25, x26, x27, x28, x29, x30, x31
   } regName_t;
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
   } aluOp_t;
   typedef struct packed {
      logic regWrite;
      logic memRead;
      logic memWrite;
      logic memToReg;
      logic aluSrc;
      logic branch;
   } ctrl_t;
   localparam ctrl_t CTRL_NOP = '0;
   localparam int BUBBLE_CNT_WIDTH = 32;
   // Drops every side-effecting enable; the mux selects are harmless and pass through.
   function automatic ctrl_t kill_enables(input ctrl_t c);
      ctrl_t r;
      r = c;
      r.regWrite = 1'b0;
      r.memRead = 1'b0;
      r.memWrite = 1'b0;
      r.branch = 1'b0;
      return r;
   endfunction
endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear and asynchronous active-low reset
//   Only built with ID_EX_BUBBLE_CNT_EN, where it counts bubbles loaded into ID/EX.
//   clk, rstN    : clock, asynchronous active-low reset
//   inc, clear   : count one (stops at all-ones), clear to zero (clear wins)
//   count        : current count
`ifdef ID_EX_BUBBLE_CNT_EN
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_q, count_d;
   always_comb count_d = clear ? '0 : (inc && count_q != '1) ? count_q + WIDTH'(1) : count_q;
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) count_q <= '0;
      else       count_q <= count_d;
   end
   assign count = count_q;
endmodule
`endif

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with stall (hold), flush (bubble) and per-entry valid
//   clk, rstN                       : clock, asynchronous active-low reset
//   stall, flush                    : hold contents / load a bubble (flush beats stall)
//   valid_in, pc_in, read1_in,
//   read2_in, imm_in, rs1_in, rs2_in,
//   rd_in, ctrl_in, aluOp_in        : decoded instruction from ID (operands already forwarded)
//   *_out                           : registered copies driving EX, 1-cycle latency
//   bubble_count                    : bubbles loaded so far, saturating (only with ID_EX_BUBBLE_CNT_EN)
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int PC_WIDTH   = 32
) (
   input  logic                         clk,
   input  logic                         rstN,
   input  logic                         stall,
   input  logic                         flush,
   input  logic                         valid_in,
   input  logic        [PC_WIDTH-1:0]   pc_in,
   input  logic signed [DATA_WIDTH-1:0] read1_in,
   input  logic signed [DATA_WIDTH-1:0] read2_in,
   input  logic signed [DATA_WIDTH-1:0] imm_in,
   input  regName_t                     rs1_in,
   input  regName_t                     rs2_in,
   input  regName_t                     rd_in,
   input  ctrl_t                        ctrl_in,
   input  aluOp_t                       aluOp_in,
   output logic                         valid_out,
   output logic        [PC_WIDTH-1:0]   pc_out,
   output logic signed [DATA_WIDTH-1:0] read1_out,
   output logic signed [DATA_WIDTH-1:0] read2_out,
   output logic signed [DATA_WIDTH-1:0] imm_out,
   output regName_t                     rs1_out,
   output regName_t                     rs2_out,
   output regName_t                     rd_out,
   output ctrl_t                        ctrl_out,
   output aluOp_t                       aluOp_out
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [BUBBLE_CNT_WIDTH-1:0]  bubble_count
`endif
);
   logic                         valid_q, valid_d;
   logic        [PC_WIDTH-1:0]   pc_q, pc_d;
   logic signed [DATA_WIDTH-1:0] read1_q, read1_d, read2_q, read2_d, imm_q, imm_d;
   regName_t                     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   ctrl_t                        ctrl_q, ctrl_d;
   aluOp_t                       aluOp_q, aluOp_d;
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      read1_d = read1_q;
      read2_d = read2_q;
      imm_d   = imm_q;
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      ctrl_d  = ctrl_q;
      aluOp_d = aluOp_q;
      if (flush) begin
         valid_d = 1'b0;
         pc_d    = '0;
         read1_d = '0;
         read2_d = '0;
         imm_d   = '0;
         rs1_d   = zero;
         rs2_d   = zero;
         rd_d    = zero;
         ctrl_d  = CTRL_NOP;
         aluOp_d = ALU_ADD;
      end else if (!stall) begin
         valid_d = valid_in;
         pc_d    = pc_in;
         read1_d = read1_in;
         read2_d = read2_in;
         imm_d   = imm_in;
         rs1_d   = rs1_in;
         rs2_d   = rs2_in;
         // an invalid entry must never reach the register file or memory
         rd_d    = valid_in ? rd_in : zero;
         ctrl_d  = valid_in ? ctrl_in : kill_enables(ctrl_in);
         aluOp_d = aluOp_in;
      end
   end
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         read1_q <= '0;
         read2_q <= '0;
         imm_q   <= '0;
         rs1_q   <= zero;
         rs2_q   <= zero;
         rd_q    <= zero;
         ctrl_q  <= CTRL_NOP;
         aluOp_q <= ALU_ADD;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         read1_q <= read1_d;
         read2_q <= read2_d;
         imm_q   <= imm_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         ctrl_q  <= ctrl_d;
         aluOp_q <= aluOp_d;
      end
   end
   assign valid_out = valid_q;
   assign pc_out    = pc_q;
   assign read1_out = read1_q;
   assign read2_out = read2_q;
   assign imm_out   = imm_q;
   assign rs1_out   = rs1_q;
   assign rs2_out   = rs2_q;
   assign rd_out    = rd_q;
   assign ctrl_out  = ctrl_q;
   assign aluOp_out = aluOp_q;
`ifdef ID_EX_BUBBLE_CNT_EN
   // a bubble is a flush, or an unstalled load of a non-instruction
   logic load_bubble;
   assign load_bubble = flush | (~stall & ~valid_in);
   sat_counter #(.WIDTH(BUBBLE_CNT_WIDTH)) u_bubble (
      .clk   (clk),
      .rstN  (rstN),
      .inc   (load_bubble),
      .clear (1'b0),
      .count (bubble_count)
   );
`endif
endmodule
